// File: rtl/img_lk_pkg.sv
// Shared types for the Lucas-Kanade structure-tensor accumulator and its downstream solver.
package img_lk_pkg;

  localparam int SOBEL_BITS = 12;
  localparam int ACC_BITS   = 48;
  localparam int COUNT_BITS = 24;
  localparam int PROD_BITS  = 2 * SOBEL_BITS;

  typedef logic signed [SOBEL_BITS-1:0] sobel_t;
  typedef logic signed [ACC_BITS-1:0]   acc_t;
  typedef logic        [COUNT_BITS-1:0] count_t;

  typedef struct packed {
    acc_t   gxx;
    acc_t   gyy;
    acc_t   gxy;
    acc_t   ex;
    acc_t   ey;
    count_t count;
  } lk_sums_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } frame_state_e;

endpackage

// File: rtl/img_lk_mac.sv
// One product+accumulate lane: registers a*b (stage 1), then accumulates it (stage 2).
module img_lk_mac
  import img_lk_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   cke,
  input  sobel_t a_i,
  input  sobel_t b_i,
  input  logic   acc_en_i,
  input  logic   acc_first_i,
  output acc_t   acc_o
);

  logic signed [PROD_BITS-1:0] prod_full;
  acc_t prod_q;
  acc_t acc_q;
  acc_t acc_d;

  assign prod_full = a_i * b_i;

  // acc_en_i/acc_first_i are stage-1 aligned, i.e. they qualify prod_q.
  always_comb begin
    acc_d = acc_q;
    if (acc_en_i) begin
      acc_d = acc_first_i ? prod_q : acc_q + prod_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else if (cke) begin
      prod_q <= acc_t'(prod_full);
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/img_lk_accumulator.sv
// Accumulates the five LK structure sums per frame and publishes them through a valid/ready holding register.
module img_lk_accumulator
  import img_lk_pkg::*;
(
  input  logic   reset_n,
  input  logic   clk,
  input  logic   cke,
  input  logic   in_valid,
  input  logic   in_first,
  input  logic   in_last,
  input  sobel_t in_diff,
  input  sobel_t in_gradx,
  input  sobel_t in_grady,
  output acc_t   m_gxx,
  output acc_t   m_gyy,
  output acc_t   m_gxy,
  output acc_t   m_ex,
  output acc_t   m_ey,
  output count_t m_count,
  output logic   m_valid,
  input  logic   m_ready,
  output logic   overrun
);

  // Output handshake: a transfer occurs on any clock edge where m_valid && m_ready;
  // m_* are held stable while m_valid && !m_ready unless a newer frame overwrites them.

  logic   s0_valid_q, s0_first_q, s0_last_q;
  sobel_t s0_dt_q, s0_gx_q, s0_gy_q;
  logic   s1_valid_q, s1_first_q, s1_last_q;

  frame_state_e state_q, state_d;
  count_t       cnt_q, cnt_d;
  logic         pub_q, pub_d;
  logic         accept;
  logic         pub_fire;

  acc_t acc_gxx, acc_gyy, acc_gxy, acc_ex, acc_ey;

  lk_sums_t out_q, out_d;
  logic     m_valid_q, m_valid_d;
  logic     overrun_q, overrun_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_q <= 1'b0;
      s0_first_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_dt_q    <= '0;
      s0_gx_q    <= '0;
      s0_gy_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (cke) begin
      s0_valid_q <= in_valid;
      s0_first_q <= in_valid & in_first;
      s0_last_q  <= in_valid & in_last;
      s0_dt_q    <= in_diff;
      s0_gx_q    <= in_gradx;
      s0_gy_q    <= in_grady;
      s1_valid_q <= s0_valid_q;
      s1_first_q <= s0_first_q;
      s1_last_q  <= s0_last_q;
    end
  end

  // Pixels outside a frame (IDLE without first) are dropped here.
  assign accept = s1_valid_q && (s1_first_q || (state_q == ST_ACC));

  img_lk_mac u_mac_gxx (.clk(clk), .reset_n(reset_n), .cke(cke), .a_i(s0_gx_q), .b_i(s0_gx_q),
                        .acc_en_i(accept), .acc_first_i(s1_first_q), .acc_o(acc_gxx));
  img_lk_mac u_mac_gyy (.clk(clk), .reset_n(reset_n), .cke(cke), .a_i(s0_gy_q), .b_i(s0_gy_q),
                        .acc_en_i(accept), .acc_first_i(s1_first_q), .acc_o(acc_gyy));
  img_lk_mac u_mac_gxy (.clk(clk), .reset_n(reset_n), .cke(cke), .a_i(s0_gx_q), .b_i(s0_gy_q),
                        .acc_en_i(accept), .acc_first_i(s1_first_q), .acc_o(acc_gxy));
  img_lk_mac u_mac_ex  (.clk(clk), .reset_n(reset_n), .cke(cke), .a_i(s0_gx_q), .b_i(s0_dt_q),
                        .acc_en_i(accept), .acc_first_i(s1_first_q), .acc_o(acc_ex));
  img_lk_mac u_mac_ey  (.clk(clk), .reset_n(reset_n), .cke(cke), .a_i(s0_gy_q), .b_i(s0_dt_q),
                        .acc_en_i(accept), .acc_first_i(s1_first_q), .acc_o(acc_ey));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pub_d   = 1'b0;
    if (accept) begin
      cnt_d = s1_first_q ? count_t'(1) : cnt_q + count_t'(1);
      if (s1_last_q) begin
        state_d = ST_IDLE;
        pub_d   = 1'b1;
      end else begin
        state_d = ST_ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pub_q   <= 1'b0;
    end else if (cke) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pub_q   <= pub_d;
    end
  end

  // A pending publish is part of the frozen pipeline, so it only fires on an enabled edge.
  assign pub_fire = pub_q && cke;

  always_comb begin
    out_d     = out_q;
    m_valid_d = m_valid_q;
    overrun_d = overrun_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (pub_fire) begin
      out_d.gxx   = acc_gxx;
      out_d.gyy   = acc_gyy;
      out_d.gxy   = acc_gxy;
      out_d.ex    = acc_ex;
      out_d.ey    = acc_ey;
      out_d.count = cnt_q;
      m_valid_d   = 1'b1;
      if (m_valid_q && !m_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_gxx   = out_q.gxx;
  assign m_gyy   = out_q.gyy;
  assign m_gxy   = out_q.gxy;
  assign m_ex    = out_q.ex;
  assign m_ey    = out_q.ey;
  assign m_count = out_q.count;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_img_lk_accumulator.sv
// Randomised bench for img_lk_accumulator with a frame-level reference model and a result scoreboard.
module tb_img_lk_accumulator;
  import img_lk_pkg::*;

  localparam int SW = $bits(lk_sums_t);

  logic   clk = 1'b0;
  logic   reset_n, cke, in_valid, in_first, in_last, m_ready, m_valid, overrun;
  sobel_t in_diff, in_gradx, in_grady;
  acc_t   m_gxx, m_gyy, m_gxy, m_ex, m_ey;
  count_t m_count;

  always #5 clk = ~clk;

  img_lk_accumulator dut (
    .reset_n(reset_n), .clk(clk), .cke(cke),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_diff(in_diff), .in_gradx(in_gradx), .in_grady(in_grady),
    .m_gxx(m_gxx), .m_gyy(m_gyy), .m_gxy(m_gxy), .m_ex(m_ex), .m_ey(m_ey),
    .m_count(m_count), .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [SW-1:0] exp_q[$];
  lk_sums_t cmp_e, held_e;
  bit rand_cke = 1'b0;
  bit cke_prev, mv_prev;

  // Frame model: sums of products since the latest first, published at last.
  acc_t        mg[5];
  int unsigned mcnt;
  bit          in_frame;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_pixel(input bit f, input bit l, input sobel_t gx, input sobel_t gy, input sobel_t dt);
    acc_t p[5];
    lk_sums_t s;
    p[0] = acc_t'(longint'(gx) * longint'(gx));
    p[1] = acc_t'(longint'(gy) * longint'(gy));
    p[2] = acc_t'(longint'(gx) * longint'(gy));
    p[3] = acc_t'(longint'(gx) * longint'(dt));
    p[4] = acc_t'(longint'(gy) * longint'(dt));
    if (f) begin
      in_frame = 1'b1;
      for (int i = 0; i < 5; i++) mg[i] = p[i];
      mcnt = 1;
    end else if (in_frame) begin
      for (int i = 0; i < 5; i++) mg[i] = mg[i] + p[i];
      mcnt++;
    end else begin
      return;
    end
    if (l) begin
      s.gxx = mg[0]; s.gyy = mg[1]; s.gxy = mg[2]; s.ex = mg[3]; s.ey = mg[4];
      s.count = count_t'(mcnt);
      exp_q.push_back(s);
      in_frame = 1'b0;
    end
  endtask

  function automatic sobel_t rs();
    return sobel_t'($urandom);
  endfunction

  // Holds one input beat until an edge with cke high has sampled it.
  task automatic drive(input bit v, input bit f, input bit l, input sobel_t gx, input sobel_t gy, input sobel_t dt);
    in_valid = v; in_first = f; in_last = l;
    in_gradx = gx; in_grady = gy; in_diff = dt;
    for (int t = 0; t < 40; t++) begin
      cke = (rand_cke && t < 39) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      if (cke) break;
    end
    if (v) model_pixel(f, l, gx, gy, dt);
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs(), rs(), rs());
  endtask

  task automatic flush_until_empty();
    bit done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      m_ready = 1'($urandom_range(0, 1));
      bubble();
      if (exp_q.size() == 0 && !m_valid) done = 1'b1;
    end
    m_ready = 1'b1;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL flush_timeout: got %0d pending results, expected 0", exp_q.size());
    end
  endtask

  always @(posedge clk) cke_prev = cke;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_valid && !mv_prev) begin
        n_cmp++;
        if (!cke_prev) begin
          n_fail++;
          $display("FAIL publish_without_cke: got publish with cke=0, expected cke=1");
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got m_valid=1 with m_gxx=0x%0h, expected no result", m_gxx);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("xfer_gxx", m_gxx, cmp_e.gxx);
          chk("xfer_gyy", m_gyy, cmp_e.gyy);
          chk("xfer_gxy", m_gxy, cmp_e.gxy);
          chk("xfer_ex", m_ex, cmp_e.ex);
          chk("xfer_ey", m_ey, cmp_e.ey);
          chk("xfer_count", m_count, cmp_e.count);
        end
      end
    end
    mv_prev = m_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cke = 1'b1; m_ready = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_diff = '0; in_gradx = '0; in_grady = '0;
    in_frame = 1'b0; mcnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_m_gxx", m_gxx, 0);
    chk("rst_m_count", m_count, 0);
    #1 reset_n = 1'b1;

    // 2x2 constant frame: literal sums and exact 3-cycle latency / 1-cycle pulse.
    rand_cke = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, i == 3, 12'sd1, 12'sd2, 12'sd3);
    for (int i = 0; i < 5; i++) begin
      chk("lat_m_valid", m_valid, (i == 3));
      if (i == 3) begin
        chk("t1_gxx", m_gxx, 4);
        chk("t1_gyy", m_gyy, 16);
        chk("t1_gxy", m_gxy, 8);
        chk("t1_ex", m_ex, 12);
        chk("t1_ey", m_ey, 24);
        chk("t1_count", m_count, 4);
      end
      bubble();
    end

    // One-pixel frame at the gradient extremes.
    drive(1'b1, 1'b1, 1'b1, -12'sd2048, 12'sd2047, -12'sd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        chk("t2_m_valid", m_valid, 1);
        chk("t2_gxx", m_gxx, acc_t'(4194304));
        chk("t2_gyy", m_gyy, acc_t'(4190209));
        chk("t2_gxy", m_gxy, acc_t'(-4192256));
        chk("t2_ex", m_ex, acc_t'(2048));
        chk("t2_ey", m_ey, acc_t'(-2047));
        chk("t2_count", m_count, 1);
      end
      bubble();
    end
    flush_until_empty();

    // Three pixels with bubbles and a toggling clock enable.
    rand_cke = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 12'sd3, -12'sd5, 12'sd7);
    bubble();
    drive(1'b1, 1'b0, 1'b0, -12'sd100, 12'sd20, -12'sd9);
    bubble();
    bubble();
    drive(1'b1, 1'b0, 1'b1, 12'sd2047, -12'sd2048, 12'sd100);
    flush_until_empty();

    // Pixels outside a frame, then a mid-frame restart.
    rand_cke = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 12'sd50, 12'sd60, 12'sd70);
    drive(1'b1, 1'b0, 1'b1, 12'sd11, 12'sd12, 12'sd13);
    drive(1'b1, 1'b1, 1'b0, 12'sd9, 12'sd9, 12'sd9);
    drive(1'b1, 1'b0, 1'b0, 12'sd8, 12'sd8, 12'sd8);
    drive(1'b1, 1'b1, 1'b0, 12'sd1, -12'sd1, 12'sd2);
    drive(1'b1, 1'b0, 1'b1, 12'sd3, 12'sd4, -12'sd5);
    flush_until_empty();

    // Randomised frames with noise, bubbles, restarts and back-pressure.
    rand_cke = 1'b1;
    for (int fr = 0; fr < 8; fr++) begin
      int len, noise;
      bit rst_px;
      len = $urandom_range(1, 12);
      noise = $urandom_range(0, 2);
      for (int i = 0; i < noise; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), rs(), rs(), rs());
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) bubble();
        rst_px = (i > 0) && (i < len - 1) && ($urandom_range(0, 7) == 0);
        drive(1'b1, (i == 0) || rst_px, i == len - 1, rs(), rs(), rs());
      end
      flush_until_empty();
    end
    chk("overrun_clear_before", overrun, 0);

    // Two frames without consumer acceptance: second overwrites first.
    m_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, rs(), rs(), rs());
    drive(1'b1, 1'b0, 1'b1, rs(), rs(), rs());
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, i == 2, rs(), rs(), rs());
    rand_cke = 1'b0;
    repeat (8) bubble();
    held_e = exp_q[$];
    chk("ovr_m_valid", m_valid, 1);
    chk("ovr_overrun", overrun, 1);
    chk("ovr_gxx", m_gxx, held_e.gxx);
    chk("ovr_ey", m_ey, held_e.ey);
    chk("ovr_count", m_count, held_e.count);
    chk("ovr_queue_depth", exp_q.size(), 2);
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    bubble();
    chk("ovr_after_xfer_valid", m_valid, 0);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_queue_empty", exp_q.size(), 0);

    // Reset mid-frame while a result is held.
    m_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 12'sd5, 12'sd6, 12'sd7);
    drive(1'b1, 1'b0, 1'b1, 12'sd8, 12'sd9, 12'sd10);
    repeat (6) bubble();
    chk("pre_rst_m_valid", m_valid, 1);
    drive(1'b1, 1'b1, 1'b0, 12'sd100, 12'sd200, 12'sd300);
    drive(1'b1, 1'b0, 1'b0, 12'sd100, 12'sd200, 12'sd300);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_m_gxx", m_gxx, 0);
    chk("arst_m_ey", m_ey, 0);
    chk("arst_m_count", m_count, 0);
    exp_q.delete();
    in_frame = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    m_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 12'sd1, 12'sd1, 12'sd1);
    rand_cke = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, i == 2, rs(), rs(), rs());
    flush_until_empty();
    chk("post_rst_overrun", overrun, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/img_lk_accumulator.md
Name: img_lk_accumulator

Overview:
Downstream consumer of the LK Sobel stage. It takes per-pixel (diff, gradx, grady) and accumulates the five Lucas-Kanade structure sums over a frame: Σgx², Σgy², Σgx·gy, Σgx·dt and Σgy·dt. It also counts the accumulated pixels. At frame end it publishes the sums through a valid/ready holding register, where the flow solver reads them.

Parameters:
SOBEL_BITS, 12, width of signed input gradients/diff (matches Sobel output)
sobel_t, logic signed [SOBEL_BITS-1:0], input sample type
ACC_BITS, 48, width of each signed accumulator
acc_t, logic signed [ACC_BITS-1:0], accumulator/output type
COUNT_BITS, 24, pixel-count width

Ports:
reset_n  input  1  asynchronous reset, active-low
clk  input  1  single clock, all logic on posedge
cke  input  1  pipeline clock enable; gates stages 0-2 only
in_valid  input  1  pixel qualifier
in_first  input  1  first pixel of frame (qualified by in_valid)
in_last  input  1  last pixel of frame (qualified by in_valid)
in_diff  input  SOBEL_BITS  temporal difference dt
in_gradx  input  SOBEL_BITS  gx
in_grady  input  SOBEL_BITS  gy
m_gxx, m_gyy, m_gxy, m_ex, m_ey  output  ACC_BITS each  frame sums (ex=Σgx·dt, ey=Σgy·dt)
m_count  output  COUNT_BITS  pixels accumulated in the frame
m_valid  output  1  result available
m_ready  input  1  consumer accept
overrun  output  1  sticky: a result was overwritten before being accepted

Behaviour:
- Reset, asynchronous on reset_n low: all pipeline valid/flag registers, accumulators, m_* data, m_count, m_valid and overrun go to 0. Reset asserted mid-frame discards the partial frame. After release, accumulation starts only at the next in_first.
- Stage 0 (cke): register in_* and the flags. Flags are masked by in_valid.
- Stage 1 (cke): five signed products of 2*SOBEL_BITS bits (gx*gx, gy*gy, gx*gy, gx*dt, gy*dt), sign-extended to ACC_BITS. Valid/first/last are forwarded.
- Stage 2 (cke), on st1_valid:
  - If first: acc = product and cnt = 1.
  - Else: acc += product and cnt += 1.
  - Accumulators and count wrap modulo 2^ACC_BITS / 2^COUNT_BITS. There is no saturation.
  - Bubbles (valid=0) leave the accumulators unchanged.
- Frame-state FSM: IDLE -> ACC on a valid first; ACC -> IDLE on a valid last.
  - Valid pixels arriving in IDLE without first are ignored (no accumulate, no count).
  - first while in ACC restarts the sums. The abandoned frame is dropped silently.
  - first and last on the same pixel is a one-pixel frame: result = that pixel's products, count = 1.
- Publish: when stage 2 processes a valid last (in ACC, or first+last), the cycle after stage 2 updates:
  - m_* are loaded with the final sums and m_count with the final count.
  - m_valid is set to 1.
- Latency: a last pixel sampled at edge k gives m_valid=1 after edge k+3 (with cke continuously high).
- Handshake, independent of cke:
  - Transfer happens when m_valid && m_ready.
  - m_valid clears after a transfer unless a new publish occurs in the same cycle, in which case the new data loads and m_valid stays 1.
  - m_* stay stable while m_valid && !m_ready.
- Overrun: a publish while m_valid && !m_ready overwrites m_* with the new frame and sets overrun=1. overrun clears only on reset.
- cke low freezes stages 0-2, including the pending publish. The output register and handshake keep operating.

Decomposition:
- Package img_lk_pkg holds:
  - the sobel_t/acc_t widths (SOBEL_BITS=12, ACC_BITS=48, COUNT_BITS=24);
  - a packed struct lk_sums_t {gxx, gyy, gxy, ex, ey, count}, reused by the downstream solver.
- One natural sub-module, img_lk_mac: a single product+accumulate lane with first/valid control, instantiated five times.
- Count, FSM and output register stay in the top.

Test Plan:
- 2x2 frame, gx=1, gy=2, dt=3 on all pixels, m_ready=1 -> gxx=4, gyy=16, gxy=8, ex=12, ey=24, count=4; m_valid high exactly 1 cycle, 3 cycles after the last pixel.
- Single pixel with first=last, gx=-2048, gy=2047, dt=-1 -> gxx=4194304, gyy=4190209, gxy=-4192256, ex=2048, ey=-2047, count=1.
- Frame of 3 pixels with bubbles interleaved and cke toggled 50% -> same sums as the contiguous run; no pulse while cke is low.
- Two back-to-back frames with m_ready=0 -> m_* hold the second frame, overrun=1. Then m_ready=1 -> one transfer, m_valid=0, overrun stays 1.
- Pixels before any first, then first restart mid-frame -> pre-first pixels ignored; result covers only the pixels from the last first to last.
- reset_n low for 1 cycle mid-frame, with m_valid=1 held -> all outputs 0 immediately (asynchronously); the following frame accumulates correctly.
